// File: rtl/psk_chan_emu.sv
// I/Q channel emulator for on-chip loopback: delay, rotation, gain, noise, DC offset, saturation.
// Optional saturation counter enabled by defining PSK_CHAN_EMU_SAT_CNT_EN.
module psk_chan_emu #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned DELAY_MAX = 16,
  parameter int unsigned NOISE_W   = 6,
  parameter logic [15:0] SEED_I    = 16'hACE1,
  parameter logic [15:0] SEED_Q    = 16'h1D2B,
  localparam int unsigned PTR_W    = $clog2(DELAY_MAX)
) (
  input  logic                     clk_16M384,
  input  logic                     rst_n_16M384,
  input  logic signed [DATA_W-1:0] DAC_I,
  input  logic signed [DATA_W-1:0] DAC_Q,
  input  logic                     DAC_vld,
  input  logic        [PTR_W-1:0]  DELAY_CNT,
  input  logic        [1:0]        ROT_CTRL,
  input  logic        [2:0]        GAIN_SHIFT,
  input  logic                     NOISE_EN,
  input  logic signed [DATA_W-1:0] DC_OFFSET,
`ifdef PSK_CHAN_EMU_SAT_CNT_EN
  input  logic                     SAT_CLR,
  output logic        [15:0]       SAT_CNT,
`endif
  output logic signed [DATA_W-1:0] ADC_I,
  output logic signed [DATA_W-1:0] ADC_Q,
  output logic                     ADC_vld
);

  localparam int unsigned EXT_W = DATA_W + 2;
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};

  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] x);
    if (x == SMIN) return SMAX;
    return -x;
  endfunction

  function automatic logic signed [DATA_W-1:0] clip(input logic signed [EXT_W-1:0] y);
    if (!y[EXT_W-1] && (y[EXT_W-2:DATA_W-1] != '0)) return SMAX;
    if (y[EXT_W-1] && (y[EXT_W-2:DATA_W-1] != '1)) return SMIN;
    return y[DATA_W-1:0];
  endfunction

  // Delay line
  logic signed [DATA_W-1:0] r_mem_i [DELAY_MAX];
  logic signed [DATA_W-1:0] r_mem_q [DELAY_MAX];
  logic [DELAY_MAX-1:0]     r_mem_v;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         w_rd_ptr;
  logic signed [DATA_W-1:0] w_dly_i, w_dly_q;
  logic                     w_dly_v;

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      r_wr_ptr <= '0;
      r_mem_v  <= '0;
      for (int k = 0; k < DELAY_MAX; k++) begin
        r_mem_i[k] <= '0;
        r_mem_q[k] <= '0;
      end
    end else begin
      r_wr_ptr          <= r_wr_ptr + 1'b1;
      r_mem_i[r_wr_ptr] <= DAC_I;
      r_mem_q[r_wr_ptr] <= DAC_Q;
      r_mem_v[r_wr_ptr] <= DAC_vld;
    end
  end

  assign w_rd_ptr = r_wr_ptr - DELAY_CNT;

  // Zero delay bypasses the array so the sample being written is read the same cycle.
  always_comb begin
    if (DELAY_CNT == '0) begin
      w_dly_i = DAC_I;
      w_dly_q = DAC_Q;
      w_dly_v = DAC_vld;
    end else begin
      w_dly_i = r_mem_i[w_rd_ptr];
      w_dly_q = r_mem_q[w_rd_ptr];
      w_dly_v = r_mem_v[w_rd_ptr];
    end
  end

  // Stage 1: carrier-phase rotation
  logic signed [DATA_W-1:0] w_rot_i, w_rot_q;
  logic signed [DATA_W-1:0] r_s1_i, r_s1_q;
  logic                     r_s1_vld;

  always_comb begin
    w_rot_i = w_dly_i;
    w_rot_q = w_dly_q;
    unique case (ROT_CTRL)
      2'd0: begin
        w_rot_i = w_dly_i;
        w_rot_q = w_dly_q;
      end
      2'd1: begin
        w_rot_i = w_dly_q;
        w_rot_q = neg_sat(w_dly_i);
      end
      2'd2: begin
        w_rot_i = neg_sat(w_dly_i);
        w_rot_q = neg_sat(w_dly_q);
      end
      2'd3: begin
        w_rot_i = neg_sat(w_dly_q);
        w_rot_q = w_dly_i;
      end
    endcase
  end

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      r_s1_i   <= '0;
      r_s1_q   <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_i   <= w_rot_i;
      r_s1_q   <= w_rot_q;
      r_s1_vld <= w_dly_v;
    end
  end

  // Noise LFSRs, x^16 + x^14 + x^13 + x^11 + 1, free-running
  logic [15:0] r_lfsr_i, r_lfsr_q;

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      r_lfsr_i <= SEED_I;
      r_lfsr_q <= SEED_Q;
    end else begin
      r_lfsr_i <= {r_lfsr_i[14:0], r_lfsr_i[15] ^ r_lfsr_i[13] ^ r_lfsr_i[12] ^ r_lfsr_i[10]};
      r_lfsr_q <= {r_lfsr_q[14:0], r_lfsr_q[15] ^ r_lfsr_q[13] ^ r_lfsr_q[12] ^ r_lfsr_q[10]};
    end
  end

  // Stage 2: gain, noise, offset, saturation
  logic signed [DATA_W-1:0]  w_sh_i, w_sh_q;
  logic signed [NOISE_W-1:0] w_noise_i, w_noise_q;
  logic signed [EXT_W-1:0]   w_sum_i, w_sum_q;

  always_comb begin
    w_sh_i    = r_s1_i >>> GAIN_SHIFT;
    w_sh_q    = r_s1_q >>> GAIN_SHIFT;
    w_noise_i = NOISE_EN ? r_lfsr_i[NOISE_W-1:0] : '0;
    w_noise_q = NOISE_EN ? r_lfsr_q[NOISE_W-1:0] : '0;
    w_sum_i   = {{2{w_sh_i[DATA_W-1]}}, w_sh_i}
              + {{(EXT_W-NOISE_W){w_noise_i[NOISE_W-1]}}, w_noise_i}
              + {{2{DC_OFFSET[DATA_W-1]}}, DC_OFFSET};
    w_sum_q   = {{2{w_sh_q[DATA_W-1]}}, w_sh_q}
              + {{(EXT_W-NOISE_W){w_noise_q[NOISE_W-1]}}, w_noise_q}
              + {{2{DC_OFFSET[DATA_W-1]}}, DC_OFFSET};
  end

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      ADC_I   <= '0;
      ADC_Q   <= '0;
      ADC_vld <= 1'b0;
    end else if (r_s1_vld) begin
      ADC_I   <= clip(w_sum_i);
      ADC_Q   <= clip(w_sum_q);
      ADC_vld <= 1'b1;
    end else begin
      ADC_I   <= '0;
      ADC_Q   <= '0;
      ADC_vld <= 1'b0;
    end
  end

`ifdef PSK_CHAN_EMU_SAT_CNT_EN
  function automatic logic ovf(input logic signed [EXT_W-1:0] y);
    return (y[EXT_W-1:DATA_W-1] != '0) && (y[EXT_W-1:DATA_W-1] != '1);
  endfunction

  logic w_rot_sat;
  logic r_s1_sat;
  logic w_sat_evt;

  always_comb begin
    w_rot_sat = 1'b0;
    unique case (ROT_CTRL)
      2'd0: w_rot_sat = 1'b0;
      2'd1: w_rot_sat = (w_dly_i == SMIN);
      2'd2: w_rot_sat = (w_dly_i == SMIN) || (w_dly_q == SMIN);
      2'd3: w_rot_sat = (w_dly_q == SMIN);
    endcase
  end

  assign w_sat_evt = r_s1_vld && (r_s1_sat || ovf(w_sum_i) || ovf(w_sum_q));

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      r_s1_sat <= 1'b0;
      SAT_CNT  <= '0;
    end else begin
      r_s1_sat <= w_rot_sat;
      if (SAT_CLR) begin
        SAT_CNT <= '0;
      end else if (w_sat_evt && (SAT_CNT != 16'hFFFF)) begin
        SAT_CNT <= SAT_CNT + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_psk_chan_emu.sv
// Directed self-checking bench for psk_chan_emu.
module tb_psk_chan_emu;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [11:0] dac_i, dac_q, dc_off;
  logic               dac_vld;
  logic        [3:0]  dly;
  logic        [1:0]  rot;
  logic        [2:0]  gain;
  logic               noise_en;
  logic signed [11:0] adc_i, adc_q;
  logic               adc_vld;
`ifdef PSK_CHAN_EMU_SAT_CNT_EN
  logic               sat_clr;
  logic        [15:0] sat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psk_chan_emu dut (
    .clk_16M384   (clk),
    .rst_n_16M384 (rst_n),
    .DAC_I        (dac_i),
    .DAC_Q        (dac_q),
    .DAC_vld      (dac_vld),
    .DELAY_CNT    (dly),
    .ROT_CTRL     (rot),
    .GAIN_SHIFT   (gain),
    .NOISE_EN     (noise_en),
    .DC_OFFSET    (dc_off),
`ifdef PSK_CHAN_EMU_SAT_CNT_EN
    .SAT_CLR      (sat_clr),
    .SAT_CNT      (sat_cnt),
`endif
    .ADC_I        (adc_i),
    .ADC_Q        (adc_q),
    .ADC_vld      (adc_vld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    dac_i = '0; dac_q = '0; dac_vld = 1'b0; dly = '0; rot = '0; gain = '0;
    noise_en = 1'b0; dc_off = '0;
`ifdef PSK_CHAN_EMU_SAT_CNT_EN
    sat_clr = 1'b0;
`endif
  endtask

  // One valid sample, then idle; returns with the d=0 result on the outputs.
  task automatic send(input int i, input int q);
    dac_i = 12'(i); dac_q = 12'(q); dac_vld = 1'b1;
    tick();
    dac_vld = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int seen;
    defaults();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (adc_i !== 12'sd0) begin errors++; $display("FAIL reset ADC_I: got %0d want 0", adc_i); end
    checks++; if (adc_q !== 12'sd0) begin errors++; $display("FAIL reset ADC_Q: got %0d want 0", adc_q); end
    checks++; if (adc_vld !== 1'b0) begin errors++; $display("FAIL reset ADC_vld: got %b want 0", adc_vld); end
`ifdef PSK_CHAN_EMU_SAT_CNT_EN
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL reset SAT_CNT: got %0d want 0", sat_cnt); end
`endif
    rst_n = 1'b1;
    dly = 4'd15;
    seen = 0;
    repeat (20) begin tick(); if (adc_vld !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_idle vld: got %0d valid cycles want 0", seen); end
    dly = 4'd0;
  endtask

  task automatic test_latency();
    int n;
    defaults();
    repeat (4) tick();
    dac_i = 12'sd100; dac_q = -12'sd50; dac_vld = 1'b1;
    tick();
    dac_vld = 1'b0;
    checks++; if (adc_vld !== 1'b0) begin errors++; $display("FAIL lat0 early vld: got %b want 0", adc_vld); end
    tick();
    checks++; if (adc_vld !== 1'b1) begin errors++; $display("FAIL lat0 vld: got %b want 1", adc_vld); end
    checks++; if (adc_i !== 12'sd100) begin errors++; $display("FAIL lat0 I: got %0d want 100", adc_i); end
    checks++; if (adc_q !== -12'sd50) begin errors++; $display("FAIL lat0 Q: got %0d want -50", adc_q); end
    tick();
    checks++; if (adc_vld !== 1'b0) begin errors++; $display("FAIL lat0 pulse width: got %b want 0", adc_vld); end
    dly = 4'd15;
    repeat (20) tick();
    dac_vld = 1'b1;
    tick();
    dac_vld = 1'b0;
    n = 1;
    while (adc_vld !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 17) begin errors++; $display("FAIL lat15 edges: got %0d want 17", n); end
    checks++; if (adc_i !== 12'sd100) begin errors++; $display("FAIL lat15 I: got %0d want 100", adc_i); end
    dly = 4'd0;
    repeat (20) tick();
  endtask

  task automatic test_rotation();
    int exp_i [4] = '{300, -200, -300, 200};
    int exp_q [4] = '{-200, -300, 200, 300};
    defaults();
    for (int r = 0; r < 4; r++) begin
      rot = 2'(r);
      send(300, -200);
      checks++; if (adc_i !== 12'(exp_i[r])) begin errors++; $display("FAIL rot%0d I: got %0d want %0d", r, adc_i, exp_i[r]); end
      checks++; if (adc_q !== 12'(exp_q[r])) begin errors++; $display("FAIL rot%0d Q: got %0d want %0d", r, adc_q, exp_q[r]); end
    end
    rot = 2'd2;
    send(-2048, 5);
    checks++; if (adc_i !== 12'sd2047) begin errors++; $display("FAIL rot_sat I: got %0d want 2047", adc_i); end
    checks++; if (adc_q !== -12'sd5) begin errors++; $display("FAIL rot_sat Q: got %0d want -5", adc_q); end
    rot = 2'd0;
  endtask

  task automatic test_gain_offset();
    int vi [4] = '{-5, 2040, -2048, -2048};
    int vq [4] = '{7, -2000, -2047, 1000};
    int vg [4] = '{1, 0, 0, 7};
    int vo [4] = '{-16, 100, -100, 0};
    int ei [4] = '{-19, 2047, -2048, -16};
    int eq [4] = '{-13, -1900, -2048, 7};
    defaults();
    for (int k = 0; k < 4; k++) begin
      gain = 3'(vg[k]); dc_off = 12'(vo[k]);
      send(vi[k], vq[k]);
      checks++; if (adc_i !== 12'(ei[k])) begin errors++; $display("FAIL gain%0d I: got %0d want %0d", k, adc_i, ei[k]); end
      checks++; if (adc_q !== 12'(eq[k])) begin errors++; $display("FAIL gain%0d Q: got %0d want %0d", k, adc_q, eq[k]); end
    end
    gain = '0; dc_off = '0;
  endtask

  task automatic test_valid_gating();
    defaults();
    dc_off = 12'sd50;
    dac_i = 12'sd10; dac_q = 12'sd20; dac_vld = 1'b1;
    tick();
    dac_vld = 1'b0;
    tick();
    checks++; if (adc_vld !== 1'b1 || adc_i !== 12'sd60 || adc_q !== 12'sd70) begin
      errors++; $display("FAIL gate first: got vld=%b I=%0d Q=%0d want 1/60/70", adc_vld, adc_i, adc_q); end
    dac_i = 12'sd30; dac_q = 12'sd40; dac_vld = 1'b1;
    tick();
    checks++; if (adc_vld !== 1'b0 || adc_i !== 12'sd0 || adc_q !== 12'sd0) begin
      errors++; $display("FAIL gate idle: got vld=%b I=%0d Q=%0d want 0/0/0", adc_vld, adc_i, adc_q); end
    dac_vld = 1'b0;
    tick();
    checks++; if (adc_vld !== 1'b1 || adc_i !== 12'sd80 || adc_q !== 12'sd90) begin
      errors++; $display("FAIL gate third: got vld=%b I=%0d Q=%0d want 1/80/90", adc_vld, adc_i, adc_q); end
    dc_off = '0;
    tick();
  endtask

`ifdef PSK_CHAN_EMU_SAT_CNT_EN
  task automatic test_sat_cnt();
    defaults();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL satcnt clear: got %0d want 0", sat_cnt); end
    rot = 2'd2;
    send(-2048, 0);
    checks++; if (sat_cnt !== 16'd1) begin errors++; $display("FAIL satcnt rot: got %0d want 1", sat_cnt); end
    rot = 2'd0;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    dc_off = 12'sd100;
    dac_i = 12'sd2040; dac_vld = 1'b1;
    repeat (3) tick();
    checks++; if (sat_cnt !== 16'd2) begin errors++; $display("FAIL satcnt stream: got %0d want 2", sat_cnt); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0; dac_vld = 1'b0;
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL satcnt clr priority: got %0d want 0", sat_cnt); end
    tick();
    checks++; if (sat_cnt !== 16'd1) begin errors++; $display("FAIL satcnt after clr: got %0d want 1", sat_cnt); end
    tick();
    checks++; if (sat_cnt !== 16'd1) begin errors++; $display("FAIL satcnt hold: got %0d want 1", sat_cnt); end
    dc_off = '0; dac_i = '0;
  endtask
`endif

  task automatic test_reset_midstream();
    int seen;
    int n;
    defaults();
    dly = 4'd8;
    dac_i = 12'sd123; dac_q = -12'sd7; dac_vld = 1'b1;
    repeat (12) tick();
    checks++; if (adc_vld !== 1'b1 || adc_i !== 12'sd123) begin
      errors++; $display("FAIL midrst pre: got vld=%b I=%0d want 1/123", adc_vld, adc_i); end
    rst_n = 1'b0;
    dac_vld = 1'b0;
    #1;
    checks++; if (adc_vld !== 1'b0 || adc_i !== 12'sd0 || adc_q !== 12'sd0) begin
      errors++; $display("FAIL midrst async: got vld=%b I=%0d Q=%0d want 0/0/0", adc_vld, adc_i, adc_q); end
`ifdef PSK_CHAN_EMU_SAT_CNT_EN
    checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL midrst SAT_CNT: got %0d want 0", sat_cnt); end
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin tick(); if (adc_vld !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst flush: got %0d valid cycles want 0", seen); end
    dac_vld = 1'b1;
    tick();
    dac_vld = 1'b0;
    n = 1;
    while (adc_vld !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 10) begin errors++; $display("FAIL midrst latency: got %0d want 10", n); end
    checks++; if (adc_i !== 12'sd123) begin errors++; $display("FAIL midrst I: got %0d want 123", adc_i); end
    dly = 4'd0;
    repeat (20) tick();
  endtask

  task automatic noise_restart();
    defaults();
    noise_en = 1'b1;
    dac_vld = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_noise();
    int run1 [64];
    int bad, sum_i, sum_q, varies, mism, vi, vq;
    bad = 0; sum_i = 0; sum_q = 0; varies = 0; mism = 0;
    noise_restart();
    for (int k = 0; k < 4096; k++) begin
      vi = int'(adc_i); vq = int'(adc_q);
      if (adc_vld !== 1'b1 || vi < -32 || vi > 31 || vq < -32 || vq > 31) bad++;
      sum_i += vi; sum_q += vq;
      if (k < 64) run1[k] = vi;
      if (k > 0 && vi != run1[0]) varies = 1;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL noise range: got %0d bad samples want 0", bad); end
    checks++; if (sum_i > 8192 || sum_i < -8192) begin errors++; $display("FAIL noise mean I: got sum %0d want |sum|<=8192", sum_i); end
    checks++; if (sum_q > 8192 || sum_q < -8192) begin errors++; $display("FAIL noise mean Q: got sum %0d want |sum|<=8192", sum_q); end
    checks++; if (varies != 1) begin errors++; $display("FAIL noise varies: got %0d want 1", varies); end
    noise_restart();
    for (int k = 0; k < 64; k++) begin
      if (int'(adc_i) != run1[k]) mism++;
      tick();
    end
    checks++; if (mism != 0) begin errors++; $display("FAIL noise repeat: got %0d differences want 0", mism); end
    noise_en = 1'b0;
    repeat (2) tick();
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (adc_vld !== 1'b1 || adc_i !== 12'sd0 || adc_q !== 12'sd0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL noise off: got %0d nonzero samples want 0", bad); end
    dac_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_latency();
    test_rotation();
    test_gain_offset();
    test_valid_gating();
`ifdef PSK_CHAN_EMU_SAT_CNT_EN
    test_sat_cnt();
`endif
    test_reset_midstream();
    test_noise();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psk_chan_emu.md
Name: psk_chan_emu

Overview:
- Synthesizable I/Q channel emulator in the 16.384 MHz domain, between Tx DAC outputs and Rx ADC inputs, for on-chip loopback.
- Applies the following to each sample, in order:
  - programmable delay;
  - 0/90/180/270° carrier-phase rotation;
  - arithmetic right-shift gain;
  - zero-mean LFSR noise;
  - signed DC offset;
  - saturation.
- Lets the demodulator's timing, phase and signal-detect loops be exercised in hardware without external RF.

Parameters:
- DATA_W, 12, signed I/Q sample width, on both input and output.
- DELAY_MAX, 16, delay-line depth. Power of two, at least 2.
- NOISE_W, 6, noise width. Noise range is -2^(NOISE_W-1) .. 2^(NOISE_W-1)-1.
- SEED_I, 16'hACE1, reset seed of the I LFSR. Must be non-zero.
- SEED_Q, 16'h1D2B, reset seed of the Q LFSR. Must be non-zero.

Ports:
- clk_16M384  in  1  sample clock.
- rst_n_16M384  in  1  asynchronous, active-low reset.
- DAC_I  in  DATA_W  signed Tx I sample.
- DAC_Q  in  DATA_W  signed Tx Q sample.
- DAC_vld  in  1  input sample valid.
- DELAY_CNT  in  log2(DELAY_MAX)  extra delay, in cycles.
- ROT_CTRL  in  2  rotation select: 0 = 0°, 1 = 90°, 2 = 180°, 3 = 270°.
- GAIN_SHIFT  in  3  arithmetic right shift, 0..7.
- NOISE_EN  in  1  enables noise addition.
- DC_OFFSET  in  DATA_W  signed offset, added to both I and Q.
- ADC_I  out  DATA_W  signed output I.
- ADC_Q  out  DATA_W  signed output Q.
- ADC_vld  out  1  output valid.

Behaviour:
- Reset state:
  - ADC_I = 0, ADC_Q = 0, ADC_vld = 0.
  - All delay-line entries are 0, with valid = 0.
  - Write pointer = 0.
  - LFSRs load SEED_I / SEED_Q.
- Delay line:
  - Circular buffer of DELAY_MAX entries {I, Q, vld}; written every cycle.
  - Write pointer increments every cycle and wraps modulo DELAY_MAX.
  - Read address = wr_ptr - DELAY_CNT, modulo DELAY_MAX.
  - DELAY_CNT = 0 reads the sample being written that cycle (write-through).
  - A change to DELAY_CNT takes effect on the next cycle. The resulting sample slip or repeat is accepted; no flush.
- Stage 1 (registered): rotation of the delayed sample (I, Q):
  - 0° → (I, Q)
  - 90° → (Q, -I)
  - 180° → (-I, -Q)
  - 270° → (-Q, I)
  - Negating -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
- Stage 2 (registered), computed in DATA_W+2 bits:
  - y = (x >>> GAIN_SHIFT) + noise + DC_OFFSET.
  - `>>>` is arithmetic, i.e. floor.
  - y is then saturated to the DATA_W signed range.
- Valid gating:
  - If the delayed valid is 0, stage 2 outputs ADC_I = ADC_Q = 0 and ADC_vld = 0.
  - In that case noise and offset are not added.
- Latency:
  - A sample presented at cycle t appears on the outputs after the clock edge ending cycle t+1+DELAY_CNT.
  - That is, 2 register stages plus DELAY_CNT.
  - Throughput is one sample per cycle.
- Noise generators:
  - Two 16-bit Fibonacci LFSRs, taps x^16+x^14+x^13+x^11+1, shifting every cycle regardless of DAC_vld or NOISE_EN.
  - noise = lfsr[NOISE_W-1:0], read as two's complement.
  - NOISE_EN = 0 forces noise to 0 while the LFSRs keep running.
- Control inputs: ROT_CTRL, GAIN_SHIFT, NOISE_EN and DC_OFFSET are sampled combinationally at the stage that uses them. No shadow registers.
- Reset mid-stream: asserting reset asynchronously clears the outputs and discards all in-flight samples. The first valid output after release arrives at the normal latency.
- Simultaneous events: none. Write and read to the same entry when DELAY_CNT = 0 is the defined write-through case.

Optional Feature:
- Macro: PSK_CHAN_EMU_SAT_CNT_EN.
- When defined:
  - Adds output SAT_CNT [15:0] and input SAT_CLR [0:0].
  - SAT_CNT increments once per stage-2 valid cycle in which I or Q saturated, including rotation saturation.
  - SAT_CNT holds at 16'hFFFF and never wraps.
  - SAT_CLR = 1 zeroes SAT_CNT on the next edge and takes priority over an increment in the same cycle.
  - SAT_CNT resets to 0.
- When undefined: those ports and logic do not exist. Datapath behaviour is identical.

Test Plan:
- Latency: DELAY_CNT = 0, ROT = 0, GAIN = 0, NOISE_EN = 0, offset = 0; one valid pulse with I = 100, Q = -50 → exactly 2 edges later ADC_I = 100, ADC_Q = -50, ADC_vld = 1 for 1 cycle. Repeat with DELAY_CNT = 15 → latency 17.
- Rotation: input (300, -200), each ROT_CTRL value → outputs (300, -200), (-200, -300), (-300, 200), (200, 300). Input I = -2048 with ROT = 2 → ADC_I = 2047.
- Gain and offset: I = -5, GAIN_SHIFT = 1, DC_OFFSET = -16 → ADC_I = -19 (floor shift). I = 2040, GAIN_SHIFT = 0, DC_OFFSET = 100 → ADC_I = 2047.
- Noise: constant I = 0, NOISE_EN = 1, 4096 valid cycles → every output is within -32..31, the mean is within ±2, and the sequence repeats after reset. With NOISE_EN = 0 → every output is 0.
- Valid gating: DAC_vld pattern 1,0,1 with DC_OFFSET = 50 → ADC_vld is 1,0,1, and ADC_I = 0 on the invalid cycle.
- Reset mid-stream: assert rst_n_16M384 low for 3 cycles while DELAY_CNT = 8 samples are in flight → outputs immediately 0 and ADC_vld = 0. After release, no valid output for 10 cycles. With PSK_CHAN_EMU_SAT_CNT_EN, SAT_CNT = 0.
